// File: rtl/fifo_packer_pkg.sv
// Shared types for the FIFO word packer.
// FSM encoding and count-width helper.
package packer_pkg;

    typedef enum logic [0:0] {
        PK_FILL,
        PK_FLUSH
    } pk_state_e;

    function automatic int cnt_width(input int pack);
        return $clog2(pack + 1);
    endfunction

endpackage

// File: rtl/fifo_packer_if.sv
// Wide-beat valid/ready bundle from the packer to the datapath.
// Master drives the beat, slave returns ready.
interface fifo_packer_if
    import packer_pkg::*;
#(
    parameter int DWIDTH = 8,
    parameter int PACK   = 4
) ();

    localparam int CWIDTH = cnt_width(PACK);

    logic                   m_valid;
    logic                   m_ready;
    logic [PACK*DWIDTH-1:0] m_data;
    logic [CWIDTH-1:0]      m_cnt;
    logic                   m_last;

    modport master (
        output m_valid,
        output m_data,
        output m_cnt,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        input  m_cnt,
        input  m_last,
        output m_ready
    );

endinterface

// File: rtl/fifo_packer.sv
// Packs PACK show-ahead FIFO words into one wide beat.
// Flush closes a partial beat; output slot is a registered stage.
module fifo_packer
    import packer_pkg::*;
#(
    parameter int DWIDTH = 8,
    parameter int PACK   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    input  logic [DWIDTH-1:0] fifo_dout,
    output logic              fifo_rden,
    input  logic              flush,
    fifo_packer_if.master     m,
    output logic              busy
);

    localparam int CWIDTH = cnt_width(PACK);
    localparam int BW     = PACK * DWIDTH;
    localparam logic [CWIDTH-1:0] FULL = CWIDTH'(PACK);

    pk_state_e         state_q, state_d;
    logic [BW-1:0]     acc_q, acc_d;
    logic [CWIDTH-1:0] cnt_q, cnt_d;
    logic [BW-1:0]     data_q, data_d;
    logic [CWIDTH-1:0] ocnt_q, ocnt_d;
    logic              last_q, last_d;
    logic              valid_q, valid_d;

    logic              ofree;
    logic              xfer;
    logic              pop;
    logic [CWIDTH-1:0] slot;

    always_comb begin
        ofree = ~valid_q | m.m_ready;
        xfer  = ofree & ((cnt_q == FULL) |
                ((state_q == PK_FLUSH) & (cnt_q != '0)));
        pop   = (state_q == PK_FILL) & ~fifo_empty &
                ((cnt_q < FULL) | xfer) & ~rst;
        slot  = xfer ? '0 : cnt_q;
    end

    always_comb begin
        acc_d = xfer ? '0 : acc_q;
        cnt_d = xfer ? '0 : cnt_q;
        if (pop) begin
            cnt_d = slot + CWIDTH'(1);
            for (int i = 0; i < PACK; i++) begin
                if (slot == CWIDTH'(i)) begin
                    acc_d[i*DWIDTH +: DWIDTH] = fifo_dout;
                end
            end
        end
    end

    always_comb begin
        data_d  = data_q;
        ocnt_d  = ocnt_q;
        last_d  = last_q;
        valid_d = valid_q;
        if (xfer) begin
            data_d  = acc_q;
            ocnt_d  = cnt_q;
            last_d  = (state_q == PK_FLUSH);
            valid_d = 1'b1;
        end else if (m.m_ready) begin
            valid_d = 1'b0;
        end
    end

    // A second flush while one is pending is dropped.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            PK_FILL: begin
                if (flush) state_d = PK_FLUSH;
            end
            PK_FLUSH: begin
                if (xfer || cnt_q == '0) state_d = PK_FILL;
            end
            default: state_d = PK_FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= PK_FILL;
            acc_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            ocnt_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            ocnt_q  <= ocnt_d;
            last_q  <= last_d;
            valid_q <= valid_d;
        end
    end

    assign fifo_rden = pop;
    assign m.m_valid = valid_q;
    assign m.m_data  = data_q;
    assign m.m_cnt   = ocnt_q;
    assign m.m_last  = last_q;
    assign busy      = (cnt_q != '0) | valid_q |
                       (state_q == PK_FLUSH);

endmodule

// File: tb/tb_fifo_packer.sv
// Scoreboard bench for fifo_packer: FIFO model, group-level
// reference model, and a beat monitor on the master port.
module tb_fifo_packer;
    import packer_pkg::*;

    localparam int DW = 8;
    localparam int PK = 4;
    localparam int CW = cnt_width(PK);
    localparam int BW = PK * DW;

    typedef struct {
        logic [BW-1:0] data;
        int            cnt;
        bit            last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fifo_empty;
    logic [DW-1:0] fifo_dout;
    logic          fifo_rden;
    logic          flush = 1'b0;
    logic          busy;

    fifo_packer_if #(.DWIDTH(DW), .PACK(PK)) mif ();

    fifo_packer #(.DWIDTH(DW), .PACK(PK)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rden  (fifo_rden),
        .flush      (flush),
        .m          (mif),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    beat_t         expq[$];
    beat_t         seen[$];
    logic [DW-1:0] fq[$];
    logic [DW-1:0] grp[$];
    bit            pending;
    bit            last_rd;
    int            checks;
    int            errors;
    beat_t         mb;
    beat_t         eb;

    task automatic chk(input string nm, input longint act,
                       input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic refresh();
        fifo_empty = (fq.size() == 0);
        fifo_dout  = (fq.size() != 0) ? fq[0] : '0;
    endtask

    task automatic push(input logic [DW-1:0] w);
        fq.push_back(w);
        refresh();
    endtask

    task automatic close_grp(input bit last);
        beat_t b;
        b.data = '0;
        for (int i = 0; i < grp.size(); i++)
            b.data[i*DW +: DW] = grp[i];
        b.cnt  = grp.size();
        b.last = last;
        expq.push_back(b);
        grp.delete();
    endtask

    // Words are collected into groups of PK; a flush closes the
    // group it lands in one cycle later, and no word is taken then.
    task automatic model_step(input bit p, input logic [DW-1:0] w,
                              input bit f);
        if (pending) begin
            chk("rden_in_flush", longint'(p), 0);
            if (grp.size() > 0) close_grp(1'b1);
            pending = 1'b0;
            return;
        end
        if (grp.size() == PK) close_grp(1'b0);
        if (p) grp.push_back(w);
        if (f) pending = 1'b1;
    endtask

    task automatic tick();
        bit            p;
        bit            f;
        logic [DW-1:0] w;
        @(negedge clk);
        p = fifo_rden;
        f = flush;
        w = fifo_dout;
        last_rd = p;
        if (!rst) model_step(p, w, f);
        @(posedge clk);
        #1;
        if (p) begin
            chk("pop_nonempty", longint'(fq.size() > 0), 1);
            if (fq.size() > 0) void'(fq.pop_front());
        end
        flush = 1'b0;
        refresh();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    always @(negedge clk) begin
        if (!rst && mif.m_valid && mif.m_ready) begin
            mb.data = mif.m_data;
            mb.cnt  = int'(mif.m_cnt);
            mb.last = mif.m_last;
            seen.push_back(mb);
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got %0h want none",
                         mb.data);
            end else begin
                eb = expq.pop_front();
                chk("beat_data", longint'(mb.data), longint'(eb.data));
                chk("beat_cnt", longint'(mb.cnt), longint'(eb.cnt));
                chk("beat_last", longint'(mb.last), longint'(eb.last));
            end
        end
    end

    initial begin
        bit            rd[12];
        logic [BW-1:0] d5;
        checks      = 0;
        errors      = 0;
        pending     = 1'b0;
        mif.m_ready = 1'b1;
        push(8'h55);
        #2;
        chk("rst_m_valid", longint'(mif.m_valid), 0);
        chk("rst_m_data", longint'(mif.m_data), 0);
        chk("rst_m_cnt", longint'(mif.m_cnt), 0);
        chk("rst_m_last", longint'(mif.m_last), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_rden", longint'(fifo_rden), 0);
        fq.delete();
        refresh();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // continuous stream
        seen.delete();
        for (int i = 1; i <= 8; i++) push(DW'(i));
        for (int i = 0; i < 12; i++) begin
            tick();
            rd[i] = last_rd;
        end
        for (int i = 0; i < 8; i++)
            chk("stream_rden", longint'(rd[i]), 1);
        chk("stream_rden_end", longint'(rd[8]), 0);
        chk("stream_nbeats", seen.size(), 2);
        if (seen.size() == 2) begin
            chk("stream_b0", longint'(seen[0].data), 32'h04030201);
            chk("stream_b1", longint'(seen[1].data), 32'h08070605);
        end

        // backpressure
        seen.delete();
        mif.m_ready = 1'b0;
        for (int i = 1; i <= 12; i++) push(DW'(i));
        d5 = '0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 5) d5 = mif.m_data;
        end
        chk("bp_rden_stop", longint'(fifo_rden), 0);
        chk("bp_valid", longint'(mif.m_valid), 1);
        chk("bp_hold", longint'(mif.m_data), 32'h04030201);
        chk("bp_stable", longint'(mif.m_data), longint'(d5));
        mif.m_ready = 1'b1;
        ticks(12);
        chk("bp_nbeats", seen.size(), 3);
        if (seen.size() == 3) begin
            chk("bp_b0", longint'(seen[0].data), 32'h04030201);
            chk("bp_b1", longint'(seen[1].data), 32'h08070605);
            chk("bp_b2", longint'(seen[2].data), 32'h0C0B0A09);
        end

        // flush of a partial beat
        seen.delete();
        push(8'hAA);
        push(8'hBB);
        ticks(2);
        flush = 1'b1;
        ticks(5);
        for (int i = 1; i <= 4; i++) push(DW'(i));
        ticks(7);
        chk("fl_nbeats", seen.size(), 2);
        if (seen.size() == 2) begin
            chk("fl_data", longint'(seen[0].data), 32'h0000BBAA);
            chk("fl_cnt", seen[0].cnt, 2);
            chk("fl_last", longint'(seen[0].last), 1);
            chk("fl_next", longint'(seen[1].data), 32'h04030201);
            chk("fl_next_last", longint'(seen[1].last), 0);
        end

        // empty flush
        seen.delete();
        chk("ef_idle", longint'(busy), 0);
        flush = 1'b1;
        tick();
        chk("ef_busy", longint'(busy), 1);
        chk("ef_rden0", longint'(fifo_rden), 0);
        tick();
        chk("ef_busy_drop", longint'(busy), 0);
        chk("ef_rden1", longint'(fifo_rden), 0);
        ticks(3);
        chk("ef_nbeats", seen.size(), 0);

        // flush in the cycle the fourth word is popped
        seen.delete();
        for (int i = 0; i < 4; i++) push(8'h11 + DW'(i));
        ticks(3);
        flush = 1'b1;
        ticks(5);
        chk("f4_nbeats", seen.size(), 1);
        if (seen.size() == 1) begin
            chk("f4_data", longint'(seen[0].data), 32'h14131211);
            chk("f4_cnt", seen[0].cnt, 4);
            chk("f4_last", longint'(seen[0].last), 1);
        end

        // reset mid-operation
        seen.delete();
        mif.m_ready = 1'b0;
        for (int i = 1; i <= 6; i++) push(DW'(i));
        ticks(7);
        push(8'h07);
        push(8'h08);
        rst = 1'b1;
        #1;
        chk("mr_valid", longint'(mif.m_valid), 0);
        chk("mr_rden", longint'(fifo_rden), 0);
        chk("mr_cnt", longint'(mif.m_cnt), 0);
        chk("mr_busy", longint'(busy), 0);
        grp.delete();
        expq.delete();
        fq.delete();
        pending = 1'b0;
        refresh();
        @(posedge clk);
        #1;
        rst = 1'b0;
        mif.m_ready = 1'b1;
        for (int i = 0; i < 4; i++) push(8'h21 + DW'(i));
        ticks(8);
        chk("mr_nbeats", seen.size(), 1);
        if (seen.size() == 1)
            chk("mr_data", longint'(seen[0].data), 32'h24232221);

        // random backpressure, no flush
        for (int i = 0; i < 300; i++) begin
            mif.m_ready = ($urandom_range(3) != 0);
            if ($urandom_range(1) == 1) push(DW'($urandom));
            tick();
        end
        mif.m_ready = 1'b1;
        ticks(30);

        // random flushes with the sink always ready
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(1) == 1) push(DW'($urandom));
            flush = ($urandom_range(7) == 0);
            tick();
        end
        ticks(10);
        flush = 1'b1;
        ticks(10);
        chk("leftover_beats", expq.size(), 0);
        chk("leftover_words", fq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_packer.md
Name: fifo_packer

Overview:
- Downstream consumer of `syncfifo`. Pops DWIDTH-bit words from the FIFO read side and packs PACK consecutive words into one PACK*DWIDTH-bit beat.
- Presents each beat on a registered valid/ready master port feeding the wide datapath.
- A flush request emits a partial beat, so packets whose length is not a multiple of PACK can be terminated.
- Sustains one FIFO pop per cycle with no bubbles while the sink is ready.

Parameters:
- DWIDTH, 8, FIFO word width in bits.
- PACK, 4, words per output beat; must be ≥ 2.
- CWIDTH, $clog2(PACK+1), width of the word-count fields (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- fifo_empty  input  1  FIFO empty flag.
- fifo_dout  input  DWIDTH  FIFO head word; show-ahead, valid whenever fifo_empty=0.
- fifo_rden  output  1  pop strobe to the FIFO (combinational).
- flush  input  1  single-cycle pulse requesting emission of the partially packed beat.
- m_valid  output  1  output beat valid.
- m_ready  input  1  sink accepts beat.
- m_data  output  PACK*DWIDTH  packed beat; word i occupies bits [i*DWIDTH +: DWIDTH], first-popped word is i=0.
- m_cnt  output  CWIDTH  number of valid words in the beat, 1..PACK.
- m_last  output  1  beat was closed by a flush.
- busy  output  1  accumulator non-empty, output register full, or flush pending.

Behaviour:
- Reset (async, rst=1): all state cleared and any partial data discarded. Output values during reset:
  - m_valid=0, m_data=0, m_cnt=0, m_last=0, busy=0.
  - fifo_rden forced to 0 while rst=1.
- Internal state:
  - accumulator acc[PACK*DWIDTH], count cnt (0..PACK).
  - output register {m_data, m_cnt, m_last, m_valid}.
  - FSM: FILL, FLUSH.
- Output slot free (ofree) = ~m_valid | m_ready.
- Transfer (xfer), acc → output register, happens in a cycle when ofree and either:
  - cnt==PACK, or
  - state==FLUSH and cnt>0.
- On xfer:
  - m_data←acc, m_cnt←cnt, m_valid←1.
  - m_last←1 if state==FLUSH, else 0.
  - Unused high words of a partial beat are zero.
- Pop condition, in both states:
  - FILL: fifo_rden = ~fifo_empty & (cnt<PACK | xfer).
  - FLUSH: fifo_rden=0 (input frozen until the partial beat leaves).
- Pop in a non-xfer cycle: word written to slot cnt; cnt←cnt+1.
- Pop in the same cycle as xfer: word written to slot 0; cnt←1. Other slots are cleared to 0.
- Xfer with no pop: cnt←0 and acc cleared.
- Sink handshake:
  - When m_valid=1 and m_ready=0 and no xfer: output register holds; m_data/m_cnt/m_last stay stable.
  - m_ready with m_valid=0 has no effect.
- FSM transitions:
  - FILL →(flush=1)→ FLUSH. A word popped in the flush cycle is included in the partial beat.
  - In FLUSH: once xfer occurs, or if cnt==0 with nothing to send, return to FILL. An empty flush produces no beat and lasts 1 cycle.
  - flush asserted while already in FLUSH is ignored.
- cnt==PACK and FLUSH: the full beat is emitted with m_cnt=PACK, m_last=1.
- Latency: word at FIFO head → visible in m_data 1 cycle after the pop that completes its beat.
- Throughput: with m_ready=1 and the FIFO non-empty, one pop every cycle and one beat every PACK cycles.

Decomposition:
- Package packer_pkg: FSM enum pk_state_e {PK_FILL, PK_FLUSH}, and a helper function computing CWIDTH from PACK.
- No sub-module: the accumulator and output register are inline.
- Instantiated beside `syncfifo`, connected as:
  - fifo_rden → `syncfifo` rden
  - `syncfifo` empty → fifo_empty
  - `syncfifo` dout → fifo_dout

Test Plan (DWIDTH=8, PACK=4):
- Continuous stream: FIFO holds 0x01..0x08, m_ready=1.
  - Expected: beats m_data=0x04030201 then 0x08070605, m_cnt=4, m_last=0, fifo_rden high 8 consecutive cycles.
- Backpressure: 12 words, m_ready=0 for 10 cycles then 1.
  - Expected: first beat 0x04030201 held stable; accumulator fills to 4 and pops stop (fifo_rden=0).
  - Then beats 0x08070605 and 0x0C0B0A09, no loss or reorder.
- Flush partial: push 0xAA,0xBB, pop both, pulse flush.
  - Expected: beat m_data=0x0000BBAA, m_cnt=2, m_last=1; next beat counts from slot 0.
- Flush with the accumulator empty and the FIFO empty.
  - Expected: no beat; busy drops 1 cycle later; fifo_rden stays 0.
- Flush when cnt reaches 4 in the same cycle.
  - Expected: single beat m_cnt=4, m_last=1.
- Reset mid-operation: assert rst after 2 of 4 words are popped and a beat is pending with m_ready=0.
  - Expected: m_valid=0 immediately, fifo_rden=0, cnt=0.
  - After release, the next 4 words form a clean beat.
